// File: rtl/imem_loader.sv
// imem_loader: packs an MSB-first byte stream into 32-bit words written to instruction RAM from word 0.
// Latency: wr_en one cycle after a word's 4th byte, peak 1 word / 5 cycles; IMEM_LOADER_CSUM_EN adds a checksum byte.
// Backpressure: byte_ready only in LOAD (and CSUM); byte_valid gaps hold all state.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CSUM, S_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       sr_q, sr_d;
  logic              err_q, err_d;
  logic              xfer, start_ok, last_word;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_bad_q, csum_bad_d;
`endif

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && (word_count != '0) && (word_count <= DEPTH_W);
  assign last_word = ({1'b0, word_idx_q} + CNT_ONE) == count_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_LOAD;
      S_LOAD:  if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
`ifdef IMEM_LOADER_CSUM_EN
      S_WRITE: state_d = last_word ? S_CSUM : S_LOAD;
      S_CSUM:  if (xfer) state_d = S_DONE;
`else
      S_WRITE: state_d = last_word ? S_DONE : S_LOAD;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = word_idx_q;
    wr_data    = '0;
    busy       = (state_q != S_IDLE);
    cpu_stall  = (state_q != S_IDLE);
    done       = 1'b0;
    err        = err_q;
    unique case (state_q)
      S_LOAD:  byte_ready = 1'b1;
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_data = sr_q;
      end
      S_CSUM:  byte_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      S_DONE: begin
        done = !csum_bad_q;
        err  = err_q | csum_bad_q;
      end
`else
      S_DONE:  done = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    err_d      = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
    csum_bad_d = csum_bad_q;
`endif
    if (state_q == S_IDLE && start) begin
      if (start_ok) begin
        count_d    = word_count;
        word_idx_d = '0;
        byte_cnt_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d     = '0;
        csum_bad_d = 1'b0;
`endif
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == S_LOAD && xfer) begin
      sr_d       = {sr_q[23:0], byte_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d     = csum_q ^ byte_data;
`endif
    end
    // The last word leaves word_idx on DEPTH-1 at most, so it never wraps.
    if (state_q == S_WRITE) begin
      byte_cnt_d = '0;
      if (!last_word) word_idx_d = word_idx_q + IDX_ONE;
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (state_q == S_CSUM && xfer) csum_bad_d = (byte_data != csum_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
      csum_bad_q <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
      csum_bad_q <= csum_bad_d;
`endif
    end
  end

endmodule
